// File: rtl/sap_clock_ctrl.sv
// SAP computer clock control: debounced single-step button, auto divider,
// halt handling and one-cycle clock-enable ticks with front-panel status.
module sap_clock_ctrl #(
    parameter int DIV_WIDTH       = 16,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   auto_mode,
    input  logic                   step_btn,
    input  logic                   halt,
    input  logic [DIV_WIDTH-1:0]   div_period,
    output logic                   clk_en,
    output logic                   sap_clk,
    output logic                   halted,
    output logic                   step_level,
    output logic [COUNT_WIDTH-1:0] tick_count
);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]           btn_sync, mode_sync;
    logic                 btn_s, mode_s, mode_q, level_q;
    logic [DB_W-1:0]      db_cnt;
    logic [DIV_WIDTH-1:0] div, div_nxt;
    logic                 mode_chg, step_req, stop, div_hit, tick;

    assign btn_s  = btn_sync[1];
    assign mode_s = mode_sync[1];

    // A step request lives for exactly the one cycle after step_level rises;
    // halt or a mode change in that cycle simply discards it.
    always_comb begin
        mode_chg = mode_s ^ mode_q;
        step_req = step_level & ~level_q;
        stop     = halt | halted;
        div_hit  = (div == div_period);
        tick     = ~stop & ~mode_chg & (mode_s ? div_hit : step_req);
        div_nxt  = div + DIV_WIDTH'(1);
        if (stop || !mode_s || mode_chg || div_hit)
            div_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_sync   <= '0;
            mode_sync  <= '0;
            mode_q     <= 1'b0;
            level_q    <= 1'b0;
            step_level <= 1'b0;
            db_cnt     <= '0;
            div        <= '0;
            clk_en     <= 1'b0;
            sap_clk    <= 1'b0;
            halted     <= 1'b0;
            tick_count <= '0;
        end else begin
            btn_sync  <= {btn_sync[0], step_btn};
            mode_sync <= {mode_sync[0], auto_mode};
            mode_q    <= mode_s;
            level_q   <= step_level;

            // Level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
            if (btn_s == step_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_MAX) begin
                db_cnt     <= '0;
                step_level <= btn_s;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end

            div        <= div_nxt;
            clk_en     <= tick;
            sap_clk    <= sap_clk ^ tick;
            tick_count <= tick_count + COUNT_WIDTH'(tick);
            if (halt)
                halted <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sap_clock_ctrl.sv
// Directed bench for sap_clock_ctrl: auto divider, debounced stepping,
// bounce rejection, halt, mode change, counter wrap and mid-debounce reset.
module tb_sap_clock_ctrl;
    logic        clk = 1'b0;
    logic        reset, auto_mode, step_btn, halt;
    logic [15:0] div_period;
    logic        clk_en, sap_clk, halted, step_level;
    logic [7:0]  tick_count;

    int total = 0;
    int bad   = 0;

    sap_clock_ctrl #(.DIV_WIDTH(16), .DEBOUNCE_CYCLES(8), .COUNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .auto_mode(auto_mode), .step_btn(step_btn),
        .halt(halt), .div_period(div_period), .clk_en(clk_en), .sap_clk(sap_clk),
        .halted(halted), .step_level(step_level), .tick_count(tick_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
    endtask

    // Advance until clk_en is seen (bounded); the outcome is itself a comparison.
    task automatic wait_tick(input string tag, input int limit);
        int seen = 0;
        for (int i = 0; i < limit && seen == 0; i++) begin
            cyc();
            if (clk_en) seen = 1;
        end
        chk(tag, seen, 1);
    endtask

    int    ticks;
    int    lvl_hi;
    logic  sclk_hold;
    logic [7:0] cnt_hold;
    int    pat [5];
    logic  pval [5];

    initial begin
        reset = 1'b1; auto_mode = 1'b0; step_btn = 1'b0; halt = 1'b0; div_period = 16'd3;

        // Reset state
        cyc(3);
        chk("rst_clk_en", clk_en, 0);
        chk("rst_sap_clk", sap_clk, 0);
        chk("rst_halted", halted, 0);
        chk("rst_step_level", step_level, 0);
        chk("rst_tick_count", tick_count, 0);

        // Auto mode, period 4
        reset = 1'b0; auto_mode = 1'b1;
        wait_tick("auto3_first_tick", 20);
        chk("auto3_count1", tick_count, 1);
        chk("auto3_sapclk1", sap_clk, 1);
        ticks = 0;
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 3; k++) begin
                cyc();
                ticks += int'(clk_en);
            end
            cyc();
            chk("auto3_period_tick", clk_en, 1);
        end
        chk("auto3_gap_ticks", ticks, 0);
        chk("auto3_count5", tick_count, 5);
        chk("auto3_sapclk5", sap_clk, 1);

        // Manual single step: press captured at E0, tick at E0+10
        auto_mode = 1'b0;
        do_reset();
        cyc(2);
        step_btn = 1'b1;
        cyc();                       // E0
        ticks = 0;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            ticks += int'(clk_en);
        end
        chk("step_early_ticks", ticks, 0);
        chk("step_level_rise", step_level, 1);
        cyc();                       // E0+10
        chk("step_tick", clk_en, 1);
        chk("step_count", tick_count, 1);
        cyc();
        chk("step_tick_one_cycle", clk_en, 0);
        cyc(9);                      // button held 20 cycles in total
        step_btn = 1'b0;
        ticks = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            ticks += int'(clk_en);
        end
        chk("release_no_tick", ticks, 0);
        chk("release_level", step_level, 0);
        chk("release_count", tick_count, 1);

        // Bounce shorter than the debounce window
        do_reset();
        pat  = '{3, 2, 5, 2, 4};
        pval = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        ticks = 0; lvl_hi = 0;
        for (int s = 0; s < 5; s++) begin
            step_btn = pval[s];
            for (int k = 0; k < pat[s]; k++) begin
                cyc();
                ticks += int'(clk_en); lvl_hi += int'(step_level);
            end
        end
        step_btn = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            ticks += int'(clk_en); lvl_hi += int'(step_level);
        end
        chk("bounce_level", lvl_hi, 0);
        chk("bounce_ticks", ticks, 0);

        // Halt with div_period=0
        div_period = 16'd0; auto_mode = 1'b1;
        do_reset();
        wait_tick("halt_first_tick", 20);
        ticks = 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            ticks += int'(clk_en);
        end
        chk("div0_continuous", ticks, 3);
        halt = 1'b1;
        cyc();
        halt = 1'b0;
        chk("halt_sets_halted", halted, 1);
        chk("halt_suppresses_tick", clk_en, 0);
        sclk_hold = sap_clk; cnt_hold = tick_count;
        auto_mode = 1'b0; step_btn = 1'b1;
        ticks = 0;
        for (int k = 0; k < 25; k++) begin
            cyc();
            ticks += int'(clk_en);
        end
        step_btn = 1'b0;
        chk("halted_no_ticks", ticks, 0);
        chk("halted_sapclk_frozen", sap_clk, sclk_hold);
        chk("halted_count_frozen", tick_count, cnt_hold);
        chk("halted_sticky", halted, 1);
        do_reset();
        chk("reset_clears_halted", halted, 0);

        // Mode change mid-count, period 10
        div_period = 16'd9; auto_mode = 1'b1;
        cyc(20);
        wait_tick("div9_tick", 30);
        cyc(3);
        auto_mode = 1'b0;
        ticks = 0;
        for (int k = 0; k < 30; k++) begin
            cyc();
            ticks += int'(clk_en);
        end
        chk("modechg_no_tick", ticks, 0);
        chk("modechg_div_zero", dut.div, 0);
        cnt_hold = tick_count;
        step_btn = 1'b1;
        ticks = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            ticks += int'(clk_en);
        end
        step_btn = 1'b0;
        chk("manual_after_change_ticks", ticks, 1);
        chk("manual_after_change_count", tick_count, 8'(cnt_hold + 8'd1));

        // tick_count wrap after 256 ticks
        div_period = 16'd0; auto_mode = 1'b1;
        do_reset();
        wait_tick("wrap_first_tick", 20);
        chk("wrap_count1", tick_count, 1);
        ticks = 0;
        for (int k = 0; k < 255; k++) begin
            cyc();
            ticks += int'(clk_en);
        end
        chk("wrap_ticks", ticks, 255);
        chk("wrap_count0", tick_count, 0);

        // Reset in the middle of a debounce
        auto_mode = 1'b0;
        do_reset();
        step_btn = 1'b1;
        cyc(5);
        reset = 1'b1; step_btn = 1'b0;
        cyc();
        reset = 1'b0;
        ticks = 0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            ticks += int'(clk_en);
        end
        chk("reset_mid_debounce_ticks", ticks, 0);
        chk("reset_mid_debounce_level", step_level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
